uart_tx_buffered: RTL and testbench

Parametrised UART transmitter with an internal transmit FIFO, runtime baud divisor, and runtime frame format (parity, 1 or 2 stop bits). It replaces the fixed single-byte transmitter in the SumLatch UART path. Upstream logic pushes words through a valid/ready handshake, and the block serialises them back-to-back onto `uart_txd` with no idle gap while data remains queued.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_sync_fifo.sv | 67 ++++++
 rtl/uart_tx_buffered.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART encodings (FSM states, parity modes, divisor floor).
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    localparam logic [1:0] c_PAR_NONE  = 2'b00;
    localparam logic [1:0] c_PAR_EVEN  = 2'b01;
    localparam logic [1:0] c_PAR_ODD   = 2'b10;

    localparam int c_MIN_DIV = 2;

    // Mode 2'b11 is reserved and behaves as no parity.
    function automatic logic par_active(input logic [1:0] mode);
        return (mode == c_PAR_EVEN) || (mode == c_PAR_ODD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync_fifo
// Brief    : Single-clock show-ahead FIFO with level output; DEPTH power of two.
// Revision : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           i_push,
    input  logic                           i_pop,
    input  logic [WIDTH-1:0]               i_wdata,
    output logic [WIDTH-1:0]               o_rdata,
    output logic                           o_full,
    output logic                           o_empty,
    output logic [$clog2(DEPTH+1)-1:0]     o_level
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_LW-1:0]  r_level;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_level == c_LW'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + c_LW'(1);
                2'b01:   r_level <= r_level - c_LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_buffered
// Brief    : FIFO-buffered UART transmitter, runtime divisor and frame format.
//            Define UART_TX_PARITY_EN to build the parity bit support.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int PAYLOAD_BITS = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int DIV_W        = 16
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [PAYLOAD_BITS-1:0]           s_data,
    input  logic [DIV_W-1:0]                  cfg_div,
    input  logic [1:0]                        cfg_parity,
    input  logic                              cfg_stop2,
    output logic                              uart_txd,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

    logic [PAYLOAD_BITS-1:0] w_fifo_rdata;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic                    w_push;
    logic                    w_pop;

    logic [2:0]              r_state;
    logic [2:0]              w_state_next;
    logic [DIV_W-1:0]        r_timer;
    logic [DIV_W-1:0]        r_div;
    logic [DIV_W-1:0]        w_div_clamped;
    logic [3:0]              r_bitcnt;
    logic [PAYLOAD_BITS-1:0] r_shift;
    logic                    r_stop2;
    logic                    r_txd;
    logic                    w_txd_next;
    logic                    w_bit_done;
    logic                    w_data_last;
    logic                    w_stop_last;
    logic                    w_frame_par;

    assign w_push   = s_valid && s_ready;
    assign s_ready  = !w_fifo_full;
    assign busy     = (r_state != c_ST_IDLE) || (fifo_level != '0);
    assign uart_txd = r_txd;

    uart_sync_fifo #(
        .WIDTH (PAYLOAD_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (s_data),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (fifo_level)
    );

    assign w_div_clamped = (cfg_div < DIV_W'(c_MIN_DIV)) ? DIV_W'(c_MIN_DIV) : cfg_div;
    assign w_bit_done    = (r_timer == r_div - DIV_W'(1));
    assign w_data_last   = (r_bitcnt == 4'(PAYLOAD_BITS - 1));
    assign w_stop_last   = (r_bitcnt == (r_stop2 ? 4'd1 : 4'd0));

`ifdef UART_TX_PARITY_EN
    logic r_par_en;
    logic r_par_bit;

    assign w_frame_par = r_par_en;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
        end else if (w_pop) begin
            r_par_en  <= par_active(cfg_parity);
            r_par_bit <= (^w_fifo_rdata) ^ (cfg_parity == c_PAR_ODD);
        end
    end
`else
    logic w_unused_parity;

    assign w_unused_parity = ^cfg_parity;
    assign w_frame_par     = 1'b0;
`endif

    // State register; the line is registered from the current state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= c_ST_IDLE;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_txd   <= w_txd_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_fifo_empty) w_state_next = c_ST_START;
            end
            c_ST_START: begin
                if (w_bit_done) w_state_next = c_ST_DATA;
            end
            c_ST_DATA: begin
                if (w_bit_done && w_data_last)
                    w_state_next = w_frame_par ? c_ST_PARITY : c_ST_STOP;
            end
`ifdef UART_TX_PARITY_EN
            c_ST_PARITY: begin
                if (w_bit_done) w_state_next = c_ST_STOP;
            end
`endif
            c_ST_STOP: begin
                if (w_bit_done && w_stop_last)
                    w_state_next = w_fifo_empty ? c_ST_IDLE : c_ST_START;
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_txd_next = 1'b1;
        w_pop      = 1'b0;
        case (r_state)
            c_ST_IDLE:   w_pop      = !w_fifo_empty;
            c_ST_START:  w_txd_next = 1'b0;
            c_ST_DATA:   w_txd_next = r_shift[0];
`ifdef UART_TX_PARITY_EN
            c_ST_PARITY: w_txd_next = r_par_bit;
`endif
            c_ST_STOP:   w_pop      = w_bit_done && w_stop_last && !w_fifo_empty;
            default:     w_txd_next = 1'b1;
        endcase
    end

    // Frame datapath: every pop relatches the word and the frame config.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_timer  <= '0;
            r_div    <= DIV_W'(c_MIN_DIV);
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_stop2  <= 1'b0;
        end else begin
            if (w_pop) begin
                r_shift <= w_fifo_rdata;
                r_div   <= w_div_clamped;
                r_stop2 <= cfg_stop2;
            end else if (r_state == c_ST_DATA && w_bit_done) begin
                r_shift <= r_shift >> 1;
            end

            if (w_pop || r_state == c_ST_IDLE || w_bit_done) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + DIV_W'(1);
            end

            if (w_state_next != r_state) begin
                r_bitcnt <= '0;
            end else if (w_bit_done) begin
                r_bitcnt <= r_bitcnt + 4'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_buffered
// Brief    : Self-checking bench for uart_tx_buffered against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buffered;

    localparam int PB    = 8;
    localparam int DEPTH = 16;
    localparam int DW    = 16;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILT = 1'b1;
`else
    localparam bit PAR_BUILT = 1'b0;
`endif

    logic          clk        = 1'b0;
    logic          resetn     = 1'b0;
    logic          s_valid    = 1'b0;
    logic          s_ready;
    logic [PB-1:0] s_data     = '0;
    logic [DW-1:0] cfg_div    = 16'd4;
    logic [1:0]    cfg_parity = 2'b00;
    logic          cfg_stop2  = 1'b0;
    logic          uart_txd;
    logic          busy;
    logic [4:0]    fifo_level;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx_buffered #(
        .PAYLOAD_BITS (PB),
        .FIFO_DEPTH   (DEPTH),
        .DIV_W        (DW)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .cfg_div    (cfg_div),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .uart_txd   (uart_txd),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic par_on(input logic [1:0] p);
        return PAR_BUILT && ((p == 2'b01) || (p == 2'b10));
    endfunction

    task automatic push(input logic [PB-1:0] w);
        s_data  = w;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (uart_txd !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, " start seen"}, 32'(n < 50), 32'd1);
    endtask

    task automatic expect_idle(input string tag);
        check({tag, " idle txd"}, 32'(uart_txd), 32'd1);
        check({tag, " idle busy"}, 32'(busy), 32'd0);
        check({tag, " idle level"}, 32'(fifo_level), 32'd0);
    endtask

    // Line levels of one frame built from the framing rules, one entry per bit
    // time; the next frame's config is driven halfway through this frame.
    task automatic expect_frame(input string tag, input logic [PB-1:0] d, input int dv,
                                input logic [1:0] p, input logic s2,
                                input int nd, input logic [1:0] np, input logic ns);
        int   eff;
        int   len;
        logic q[$];
        eff = (dv < 2) ? 2 : dv;
        q.push_back(1'b0);
        for (int i = 0; i < PB; i++) q.push_back(d[i]);
        if (par_on(p)) q.push_back((^d) ^ (p == 2'b10));
        q.push_back(1'b1);
        if (s2) q.push_back(1'b1);
        len = eff * q.size();
        for (int k = 0; k < len; k++) begin
            check($sformatf("%s txd bit%0d cyc%0d", tag, k / eff, k), 32'(uart_txd), 32'(q[k / eff]));
            if (k < len - 1) check($sformatf("%s busy cyc%0d", tag, k), 32'(busy), 32'd1);
            if (k == len / 2) begin
                cfg_div    = DW'(nd);
                cfg_parity = np;
                cfg_stop2  = ns;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PB-1:0] w   [3];
        int            dv  [4];
        logic [1:0]    pm  [4];
        logic          s2m [4];
        int            nw;
        int            acc;
        int            cyc;
        int            lows;

        // Reset state, held and after release
        repeat (3) @(negedge clk);
        check("rst txd", 32'(uart_txd), 32'd1);
        check("rst s_ready", 32'(s_ready), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst level", 32'(fifo_level), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        expect_idle("post-rst");

        // Basic frame with exact push-to-start latency
        cfg_div = 16'd4; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        push(8'hA5);
        check("basic e0 txd", 32'(uart_txd), 32'd1);
        check("basic e0 level", 32'(fifo_level), 32'd1);
        check("basic e0 busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("basic e1 txd", 32'(uart_txd), 32'd1);
        check("basic e1 level", 32'(fifo_level), 32'd0);
        check("basic e1 busy", 32'(busy), 32'd1);
        @(negedge clk);
        expect_frame("basic", 8'hA5, 4, 2'b00, 1'b0, 4, 2'b00, 1'b0);
        expect_idle("basic");

        // Parity even then odd
        cfg_parity = 2'b01;
        push(8'h07);
        wait_start("par-even");
        expect_frame("par-even", 8'h07, 4, 2'b01, 1'b0, 4, 2'b10, 1'b0);
        expect_idle("par-even");
        push(8'h07);
        wait_start("par-odd");
        expect_frame("par-odd", 8'h07, 4, 2'b10, 1'b0, 4, 2'b00, 1'b0);
        expect_idle("par-odd");

        // Back-to-back with two stop bits
        cfg_parity = 2'b00; cfg_stop2 = 1'b1;
        push(8'h55);
        push(8'h0F);
        wait_start("b2b");
        expect_frame("b2b-0", 8'h55, 4, 2'b00, 1'b1, 4, 2'b00, 1'b1);
        expect_frame("b2b-1", 8'h0F, 4, 2'b00, 1'b1, 4, 2'b00, 1'b0);
        expect_idle("b2b");

        // Divisor change mid-frame only affects the next frame
        push(8'h3C);
        push(8'hC3);
        wait_start("cfgstab");
        expect_frame("cfgstab-0", 8'h3C, 4, 2'b00, 1'b0, 8, 2'b00, 1'b0);
        expect_frame("cfgstab-1", 8'hC3, 8, 2'b00, 1'b0, 4, 2'b00, 1'b0);
        expect_idle("cfgstab");

        // Randomized bursts: divisor 0..6 covers the clamp, all parity codes
        for (int it = 0; it < 12; it++) begin
            nw = $urandom_range(1, 3);
            for (int f = 0; f < 4; f++) begin
                dv[f]  = $urandom_range(0, 6);
                pm[f]  = 2'($urandom_range(0, 3));
                s2m[f] = 1'($urandom_range(0, 1));
            end
            for (int f = 0; f < 3; f++) w[f] = PB'($urandom);
            cfg_div = DW'(dv[0]); cfg_parity = pm[0]; cfg_stop2 = s2m[0];
            for (int f = 0; f < nw; f++) push(w[f]);
            wait_start($sformatf("rnd%0d", it));
            for (int f = 0; f < nw; f++)
                expect_frame($sformatf("rnd%0d-%0d", it, f), w[f], dv[f], pm[f], s2m[f],
                             dv[f + 1], pm[f + 1], s2m[f + 1]);
            expect_idle($sformatf("rnd%0d", it));
        end

        // FIFO fill with continuous valid
        cfg_div = 16'd100; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        acc = 0;
        s_data  = PB'($urandom);
        s_valid = 1'b1;
        for (int i = 0; i < 25; i++) begin
            if (s_ready) acc++;
            @(negedge clk);
            s_data = PB'($urandom);
        end
        s_valid = 1'b0;
        check("fill accepted", 32'(acc), 32'(DEPTH + 1));
        check("fill level", 32'(fifo_level), 32'(DEPTH));
        check("fill s_ready", 32'(s_ready), 32'd0);
        cyc = 24;
        while (!s_ready && cyc < 1100) begin
            @(negedge clk);
            cyc++;
        end
        check("fill ready edge", 32'(cyc), 32'd1001);
        check("fill level after pop", 32'(fifo_level), 32'(DEPTH - 1));
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Reset during DATA with three words queued
        cfg_div = 16'd4;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        repeat (7) @(negedge clk);
        check("rstmid level", 32'(fifo_level), 32'd3);
        resetn = 1'b0;
        @(negedge clk);
        check("rstmid txd", 32'(uart_txd), 32'd1);
        check("rstmid level0", 32'(fifo_level), 32'd0);
        check("rstmid busy", 32'(busy), 32'd0);
        check("rstmid s_ready", 32'(s_ready), 32'd1);
        resetn = 1'b1;
        lows = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (uart_txd !== 1'b1) lows++;
        end
        check("rstmid silent", 32'(lows), 32'd0);
        expect_idle("rstmid");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
